dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer for the 256-word single-cycle data memory. It sits between the CPU load/store path (port 0) and the program-loader/debug path (port 1), and is the only driver of the memory's address, enable and write-data pins. It grants one access at a time, guarantees the memory never sees read and write enables together, and returns read data and a completion pulse to the winning port.

## Interface
- ADDR_W, 8: implemented word-address bits; memory depth is 2^ADDR_W (256).
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- p0_req / p1_req  in  1  access request; must be held until the matching gnt.
- p0_we / p1_we  in  1  1 = write, 0 = read; sampled with req.
- p0_addr / p1_addr  in  32  word address.
- p0_wdata / p1_wdata  in  32  write data.
- p0_gnt / p1_gnt  out  1  one-cycle pulse: command accepted.
- p0_done / p1_done  out  1  one-cycle pulse: access complete.
- p0_err / p1_err  out  1  valid with done: address out of range.
- p0_rdata / p1_rdata  out  32  read result; holds until that port's next read completes.
- mem_addr  out  32  to memory Address; zero-extended addr[ADDR_W-1:0].
- mem_we / mem_re  out  1  to memory writeenable / readenable.
- mem_wdata  out  32  to memory writedata.
- mem_rdata  in  32  from memory outdata.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if neither req is set, stay. If either is set, pick a winner, latch we/addr/wdata into command registers, set the winner's gnt for the next cycle, and go to ACCESS.
- Round-robin arbitration: a `last` pointer holds the most recently granted port. On a tie, the other port wins. `last` updates on every grant.
- Range check: the address is in range when addr[31:ADDR_W]==0.
- ACCESS, in range, write: mem_we=1, mem_re=0.
- ACCESS, in range, read: mem_re=1, mem_we=0.
- ACCESS, out of range: both enables are 0, and the error is latched.
- Always go to DONE after ACCESS.
- At the posedge that ends ACCESS: for an in-range read, capture mem_rdata into the winner's rdata. For an out-of-range read, load 0.
- DONE: pulse the winner's done, with err as latched. Enables are 0. Return to IDLE.
- A req still high in DONE/IDLE is treated as a new request. Requesters must drop req after gnt to avoid a repeat.
- mem_we and mem_re are never 1 together in any cycle.
- Reset values: state=IDLE, last=1 (port 0 wins the first tie). All gnt/done/err=0, rdata=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0.
- Reset mid-operation forces the reset values immediately. The aborted access gets no done. A write whose ACCESS cycle is cut by reset before its closing posedge does not update memory.

## Timing
- req is sampled at posedge N while in IDLE.
- gnt and all mem_* outputs are valid during cycle N+1 (ACCESS). All mem_* outputs are registered.
- The memory reads on the negedge inside ACCESS and writes at the posedge ending ACCESS (N+2).
- done, err and the updated rdata are visible during cycle N+2 (DONE).
- Earliest next grant is sampled at posedge N+3. Throughput is one access per 3 cycles.
- gnt and done are exactly one cycle wide and never both high on the same port.

## Configuration
- DMEM_ARB_FIXED_PRIO_EN defined: fixed priority, port 0 always wins a tie, and `last` is unused. Port 1 can starve.
- Undefined (default): round-robin as described above.

## Test plan
- Single write then read, port 0: write addr 5, data 0xDEADBEEF, then read addr 5. Expect gnt at N+1 and done at N+2 for each access. Expect p0_rdata=0xDEADBEEF and err=0.
- Simultaneous requests after reset: p0 and p1 both read, held until gnt. Expect p0 granted first, then p1. Check that mem_we/mem_re are never both high on any cycle.
- Continuous contention, both reqs always high: grants alternate p0, p1, p0, p1 with one access every 3 cycles. With DMEM_ARB_FIXED_PRIO_EN, p0 gets every grant.
- Out of range: p1 writes addr 0x100 (ADDR_W=8). Expect mem_we=0 throughout, p1_done=1 with p1_err=1, and memory word 0 unchanged.
- Reset mid-access: assert reset during the ACCESS cycle of a write to addr 7 with data 0x1234. Expect all outputs to drop to 0 asynchronously, no done pulse, and word 7 keeps its old value on a later read.
- rdata hold: p0 reads 0xAA from addr 3, then p0 writes addr 4. Expect p0_rdata to stay 0xAA after the write's done.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter/sequencer in front of the single-cycle data memory.
//   Port 0 is the CPU load/store path, port 1 the loader/debug path. One
//   access is in flight at a time and takes three cycles: IDLE (sample/grant),
//   ACCESS (memory enables driven), DONE (completion pulse back to the winner).
//
//   Build option: DMEM_ARB_FIXED_PRIO_EN
//     defined   -> port 0 always wins a tie (port 1 can starve)
//     undefined -> round-robin, the port not granted last wins a tie
//
//   Ports
//     clk, reset            system clock, asynchronous active-high reset
//     pN_req/we/addr/wdata  request from port N, held until pN_gnt
//     pN_gnt                one-cycle pulse, command accepted (ACCESS cycle)
//     pN_done/pN_err        one-cycle completion pulse, err = address out of range
//     pN_rdata              last read result of port N, held until its next read
//     mem_addr/we/re/wdata  registered memory controls
//     mem_rdata             memory read data (valid at the end of ACCESS)
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for a request; arbitrates and latches the command
//   S_ACCESS | memory enables asserted for the granted command
//   S_DONE   | done/err pulse to the granted port

module dmem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_port;
  logic        r_cmd_we;
  logic        r_cmd_oor;
  logic [1:0]  r_gnt;
  logic [1:0]  r_done;
  logic [1:0]  r_err;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_we;
  logic        r_mem_re;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic        r_last;
`endif

  logic        w_any;
  logic        w_win;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_in_range;

  assign w_any = p0_req | p1_req;

  // Winner only matters when w_any is set; with a single requester it is that one.
`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign w_win = ~p0_req;
`else
  assign w_win = (p0_req & p1_req) ? ~r_last : ~p0_req;
`endif

  assign w_sel_we    = w_win ? p1_we    : p0_we;
  assign w_sel_addr  = w_win ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_win ? p1_wdata : p0_wdata;
  assign w_in_range  = ~|w_sel_addr[31:ADDR_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_port      <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_oor   <= 1'b0;
      r_gnt       <= 2'b00;
      r_done      <= 2'b00;
      r_err       <= 2'b00;
      r_rdata0    <= 32'd0;
      r_rdata1    <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      r_last      <= 1'b1;
`endif
    end else begin
      // Pulses and enables default low; each lives for exactly one state.
      r_gnt    <= 2'b00;
      r_done   <= 2'b00;
      r_err    <= 2'b00;
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_port      <= w_win;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            r_last      <= w_win;
`endif
            r_cmd_we    <= w_sel_we;
            r_cmd_oor   <= ~w_in_range;
            r_gnt[w_win] <= 1'b1;
            r_mem_addr  <= {{(32-ADDR_W){1'b0}}, w_sel_addr[ADDR_W-1:0]};
            r_mem_wdata <= w_sel_wdata;
            // Out-of-range commands keep both enables low; the two enables
            // are mutually exclusive by construction through w_sel_we.
            r_mem_we    <= w_sel_we & w_in_range;
            r_mem_re    <= ~w_sel_we & w_in_range;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_done[r_port] <= 1'b1;
          r_err[r_port]  <= r_cmd_oor;
          if (!r_cmd_we) begin
            if (r_port) r_rdata1 <= r_cmd_oor ? 32'd0 : mem_rdata;
            else        r_rdata0 <= r_cmd_oor ? 32'd0 : mem_rdata;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign p0_gnt    = r_gnt[0];
  assign p1_gnt    = r_gnt[1];
  assign p0_done   = r_done[0];
  assign p1_done   = r_done[1];
  assign p0_err    = r_err[0];
  assign p1_err    = r_err[1];
  assign p0_rdata  = r_rdata0;
  assign p1_rdata  = r_rdata1;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;

endmodule
